vram_write_arbiter: RTL and testbench

- Shares the single VRAM write port (vram_we / vram_addr / vram_data) between two requesters:
  - CPU store traffic decoded by the MIO bus.
  - A hardware fill engine that writes a constant colour over a linear address range (screen clear, rectangle row fill).
- CPU writes are buffered in a small FIFO so the bus never stalls on a fill.
- Writes are granted round-robin, one VRAM write per clock.
- Sits between the MIO bus decode and the VRAM write port of the VGA frame buffer.

---
 rtl/vram_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vram_write_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: shares the VRAM write port between buffered CPU
// stores and a constant-colour linear fill engine, one write per clock,
// round-robin under contention.
//
// Fill engine states:
//   state  | meaning
//   IDLE   | waiting for fill_start; fill inputs latched on start
//   RUN    | requesting one fill write per grant, address wraps at end of VRAM
//   DONE   | one-cycle fill_done pulse, then back to IDLE
module vram_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int VRAM_WORDS = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [17:0] cpu_addr,
    input  logic [11:0] cpu_data,
    output logic        cpu_full,
    output logic        cpu_ovf,
    input  logic        fill_start,
    input  logic [17:0] fill_base,
    input  logic [17:0] fill_len,
    input  logic [11:0] fill_color,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        vram_we,
    output logic [17:0] vram_addr,
    output logic [11:0] vram_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [17:0]      LAST_ADDR = 18'(VRAM_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [29:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;

    logic [1:0]       state_q, state_d;
    logic [17:0]      fill_addr_q, fill_addr_d;
    logic [17:0]      fill_rem_q, fill_rem_d;
    logic [11:0]      fill_col_q, fill_col_d;

    // 1 = CPU took the last grant; reset value 0 (fill) lets the CPU win first
    logic             last_cpu_q, last_cpu_d;
    logic             we_q, we_d;
    logic [17:0]      addr_q, addr_d;
    logic [11:0]      data_q, data_d;

    logic             push, cpu_pend, fill_pend, grant_cpu, grant_fill;
    logic [29:0]      fifo_head;

    assign push       = cpu_wr && !full_q;
    assign cpu_pend   = (count_q != '0);
    assign fill_pend  = (state_q == S_RUN);
    assign grant_cpu  = cpu_pend && (!fill_pend || !last_cpu_q);
    assign grant_fill = fill_pend && !grant_cpu;
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // CPU FIFO pointers, occupancy, full and sticky overflow
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = grant_cpu ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, grant_cpu})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_C);
        ovf_d  = ovf_q | (cpu_wr && full_q);
    end

    // Fill engine next state; inputs are only sampled on an accepted start
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_rem_d  = fill_rem_q;
        fill_col_d  = fill_col_q;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    fill_addr_d = fill_base;
                    fill_rem_d  = fill_len;
                    fill_col_d  = fill_color;
                    state_d     = (fill_len == 18'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (grant_fill) begin
                    fill_addr_d = (fill_addr_q >= LAST_ADDR) ? 18'd0 : fill_addr_q + 18'd1;
                    fill_rem_d  = fill_rem_q - 18'd1;
                    if (fill_rem_q == 18'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write port mux and round-robin bookkeeping; address/data hold when idle
    always_comb begin
        we_d       = grant_cpu | grant_fill;
        addr_d     = addr_q;
        data_d     = data_q;
        last_cpu_d = last_cpu_q;
        if (grant_cpu) begin
            addr_d     = fifo_head[29:12];
            data_d     = fifo_head[11:0];
            last_cpu_d = 1'b1;
        end else if (grant_fill) begin
            addr_d     = fill_addr_q;
            data_d     = fill_col_q;
            last_cpu_d = 1'b0;
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cpu_addr, cpu_data};
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_col_q  <= '0;
            last_cpu_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            fill_rem_q  <= fill_rem_d;
            fill_col_q  <= fill_col_d;
            last_cpu_q  <= last_cpu_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign cpu_full  = full_q;
    assign cpu_ovf   = ovf_q;
    assign fill_busy = (state_q == S_RUN);
    assign fill_done = (state_q == S_DONE);
    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_data = data_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: expected writes are queued
// when stimulus is driven and matched by a monitor as they reach the port.
module tb_vram_write_arbiter;

    typedef struct packed {
        logic [17:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_wr = 1'b0;
    logic [17:0] cpu_addr = '0;
    logic [11:0] cpu_data = '0;
    logic        cpu_full, cpu_ovf;
    logic        fill_start = 1'b0;
    logic [17:0] fill_base = '0;
    logic [17:0] fill_len = '0;
    logic [11:0] fill_color = '0;
    logic        fill_busy, fill_done;
    logic        vram_we;
    logic [17:0] vram_addr;
    logic [11:0] vram_data;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    wr_t cpu_exp_q[$];
    wr_t fill_exp_q[$];
    int  src_log[$];

    vram_write_arbiter #(.FIFO_DEPTH(4), .VRAM_WORDS(76800)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_full(cpu_full), .cpu_ovf(cpu_ovf),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
    );

    always #5 clk = ~clk;

    // Monitor: every write must match the fill head or the CPU head in order
    always @(negedge clk) begin
        if (!rst) begin
            if (vram_we) begin
                we_cnt++;
                checks++;
                if (fill_exp_q.size() > 0 && vram_addr === fill_exp_q[0].addr
                    && vram_data === fill_exp_q[0].data) begin
                    void'(fill_exp_q.pop_front());
                    src_log.push_back(1);
                end else if (cpu_exp_q.size() > 0) begin
                    if ({vram_addr, vram_data} !== cpu_exp_q[0]) begin
                        failures++;
                        $display("FAIL vram_write got addr=%h data=%h expected addr=%h data=%h",
                                 vram_addr, vram_data, cpu_exp_q[0].addr, cpu_exp_q[0].data);
                    end
                    void'(cpu_exp_q.pop_front());
                    src_log.push_back(0);
                end else begin
                    failures++;
                    $display("FAIL unexpected_write got addr=%h data=%h expected no write",
                             vram_addr, vram_data);
                end
            end
            if (fill_done) done_cnt++;
        end
    end

    // One bench cycle: past the falling edge, monitor already updated
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            nxt();
            if (fill_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nxt();
        nxt();
        checks++;
        if ({vram_we, vram_addr, vram_data, cpu_full, cpu_ovf, fill_busy, fill_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b addr=%h data=%h full=%b ovf=%b busy=%b done=%b expected all 0",
                     vram_we, vram_addr, vram_data, cpu_full, cpu_ovf, fill_busy, fill_done);
        end
        rst = 1'b0;
        nxt();
    endtask

    task automatic test_single_cpu();
        int base;
        base = we_cnt;
        cpu_wr = 1'b1; cpu_addr = 18'h00010; cpu_data = 12'hF00;
        cpu_exp_q.push_back({18'h00010, 12'hF00});
        nxt();
        cpu_wr = 1'b0;
        checks++;
        if (vram_we !== 1'b0) begin
            failures++;
            $display("FAIL single_lat1 got we=%b expected 0", vram_we);
        end
        nxt();
        checks++;
        if (vram_we !== 1'b1 || vram_addr !== 18'h00010 || vram_data !== 12'hF00) begin
            failures++;
            $display("FAIL single_lat2 got we=%b addr=%h data=%h expected we=1 addr=00010 data=f00",
                     vram_we, vram_addr, vram_data);
        end
        nxt();
        checks++;
        if (vram_we !== 1'b0 || vram_addr !== 18'h00010 || we_cnt - base != 1) begin
            failures++;
            $display("FAIL single_once got we=%b addr=%h writes=%0d expected we=0 addr held=00010 writes=1",
                     vram_we, vram_addr, we_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = we_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                cpu_wr = 1'b1; cpu_addr = 18'(32'h1000 + i); cpu_data = 12'(32'h600 + i);
                cpu_exp_q.push_back({18'(32'h1000 + i), 12'(32'h600 + i)});
            end else begin
                cpu_wr = 1'b0;
            end
            nxt();
            checks++;
            if (cpu_full !== 1'b0) begin
                failures++;
                $display("FAIL b2b_full cycle=%0d got full=%b expected 0", i, cpu_full);
            end
        end
        checks++;
        if (we_cnt - base != 4 || cpu_exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got writes=%0d left=%0d expected writes=4 left=0",
                     we_cnt - base, cpu_exp_q.size());
        end
    endtask

    task automatic test_fill_alone();
        int base, dbase;
        logic [17:0] exp_a[4];
        base = we_cnt; dbase = done_cnt;
        exp_a = '{18'h12BFE, 18'h12BFF, 18'h00000, 18'h00001};
        fill_start = 1'b1; fill_base = 18'h12BFE; fill_len = 18'd4; fill_color = 12'h0F0;
        for (int i = 0; i < 4; i++) fill_exp_q.push_back({exp_a[i], 12'h0F0});
        nxt();
        fill_start = 1'b0;
        checks++;
        if (fill_busy !== 1'b1 || vram_we !== 1'b0) begin
            failures++;
            $display("FAIL fill_start_state got busy=%b we=%b expected busy=1 we=0", fill_busy, vram_we);
        end
        for (int i = 0; i < 4; i++) begin
            nxt();
            checks++;
            if (vram_we !== 1'b1 || vram_addr !== exp_a[i]) begin
                failures++;
                $display("FAIL fill_seq idx=%0d got we=%b addr=%h expected we=1 addr=%h",
                         i, vram_we, vram_addr, exp_a[i]);
            end
        end
        // DONE is entered on the edge that registers the last granted write
        checks++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_done_pulse got done=%b busy=%b expected done=1 busy=0", fill_done, fill_busy);
        end
        nxt();
        checks++;
        if (fill_done !== 1'b0 || vram_we !== 1'b0 || we_cnt - base != 4 || done_cnt - dbase != 1) begin
            failures++;
            $display("FAIL fill_end got done=%b we=%b writes=%0d dones=%0d expected 0 0 4 1",
                     fill_done, vram_we, we_cnt - base, done_cnt - dbase);
        end
    endtask

    task automatic test_contention();
        int n, first, last;
        int exp_src[9];
        exp_src = '{0, 1, 0, 1, 0, 1, 1, 1, 1};
        src_log.delete();
        n = 0; first = -1; last = -1;
        fill_start = 1'b1; fill_base = 18'h00400; fill_len = 18'd6; fill_color = 12'h00F;
        for (int i = 0; i < 6; i++) fill_exp_q.push_back({18'(32'h400 + i), 12'h00F});
        cpu_wr = 1'b1; cpu_addr = 18'h00100; cpu_data = 12'h800;
        cpu_exp_q.push_back({18'h00100, 12'h800});
        for (int cyc = 1; cyc <= 20; cyc++) begin
            nxt();
            fill_start = 1'b0;
            if (cyc <= 2) begin
                cpu_wr = 1'b1; cpu_addr = 18'(32'h100 + cyc); cpu_data = 12'(32'h800 + cyc);
                cpu_exp_q.push_back({18'(32'h100 + cyc), 12'(32'h800 + cyc)});
            end else begin
                cpu_wr = 1'b0;
            end
            if (vram_we) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        checks++;
        if (n != 9 || last - first + 1 != 9) begin
            failures++;
            $display("FAIL contention_span got writes=%0d span=%0d expected 9 and 9", n, last - first + 1);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= src_log.size() || src_log[i] != exp_src[i]) begin
                failures++;
                $display("FAIL contention_order idx=%0d got src=%0d expected src=%0d (0=cpu 1=fill)",
                         i, (i < src_log.size()) ? src_log[i] : -1, exp_src[i]);
            end
        end
        checks++;
        if (cpu_exp_q.size() != 0 || fill_exp_q.size() != 0) begin
            failures++;
            $display("FAIL contention_drain got cpu_left=%0d fill_left=%0d expected 0 0",
                     cpu_exp_q.size(), fill_exp_q.size());
        end
    endtask

    task automatic test_overflow();
        bit seen;
        bit accept[10];
        logic exp_full, exp_ovf;
        accept = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
        fill_start = 1'b1; fill_base = 18'h00800; fill_len = 18'd100; fill_color = 12'h0AA;
        for (int i = 0; i < 100; i++) fill_exp_q.push_back({18'(32'h800 + i), 12'h0AA});
        for (int cyc = 1; cyc <= 11; cyc++) begin
            nxt();
            fill_start = 1'b0;
            exp_full = (cyc == 8 || cyc == 10);
            exp_ovf  = (cyc >= 9);
            checks++;
            if (cpu_full !== exp_full || cpu_ovf !== exp_ovf) begin
                failures++;
                $display("FAIL ovf_flags cycle=%0d got full=%b ovf=%b expected full=%b ovf=%b",
                         cyc, cpu_full, cpu_ovf, exp_full, exp_ovf);
            end
            if (cyc <= 10) begin
                cpu_wr = 1'b1; cpu_addr = 18'(32'h2000 + cyc - 1); cpu_data = 12'(32'h300 + cyc - 1);
                if (accept[cyc-1]) cpu_exp_q.push_back({18'(32'h2000 + cyc - 1), 12'(32'h300 + cyc - 1)});
            end else begin
                cpu_wr = 1'b0;
            end
        end
        wait_done(200, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL ovf_fill_timeout got no fill_done expected fill_done within 200 cycles");
        end
        nxt();
        nxt();
        checks++;
        if (cpu_exp_q.size() != 0 || fill_exp_q.size() != 0 || cpu_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain got cpu_left=%0d fill_left=%0d ovf=%b expected 0 0 1",
                     cpu_exp_q.size(), fill_exp_q.size(), cpu_ovf);
        end
    endtask

    task automatic test_zero_restart();
        int base, dbase;
        bit seen;
        base = we_cnt; dbase = done_cnt;
        fill_start = 1'b1; fill_base = 18'h00005; fill_len = 18'd0; fill_color = 12'h111;
        nxt();
        fill_start = 1'b0;
        checks++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done got done=%b busy=%b expected done=1 busy=0", fill_done, fill_busy);
        end
        for (int i = 0; i < 4; i++) nxt();
        checks++;
        if (we_cnt != base || done_cnt - dbase != 1) begin
            failures++;
            $display("FAIL zero_len_nowrite got writes=%0d dones=%0d expected 0 1", we_cnt - base, done_cnt - dbase);
        end
        base = we_cnt; dbase = done_cnt;
        fill_start = 1'b1; fill_base = 18'h00100; fill_len = 18'd5; fill_color = 12'h222;
        for (int i = 0; i < 5; i++) fill_exp_q.push_back({18'(32'h100 + i), 12'h222});
        nxt();
        fill_start = 1'b0;
        nxt();
        fill_start = 1'b1; fill_base = 18'h03000; fill_len = 18'd2; fill_color = 12'h333;
        nxt();
        fill_start = 1'b0;
        wait_done(30, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL restart_timeout got no fill_done expected fill_done within 30 cycles");
        end
        for (int i = 0; i < 4; i++) nxt();
        checks++;
        if (we_cnt - base != 5 || done_cnt - dbase != 1 || fill_exp_q.size() != 0) begin
            failures++;
            $display("FAIL restart_ignored got writes=%0d dones=%0d fill_left=%0d expected 5 1 0",
                     we_cnt - base, done_cnt - dbase, fill_exp_q.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        int base, dbase;
        fill_start = 1'b1; fill_base = 18'h00040; fill_len = 18'd50; fill_color = 12'h444;
        for (int i = 0; i < 50; i++) fill_exp_q.push_back({18'(32'h40 + i), 12'h444});
        nxt();
        fill_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1'b1; cpu_addr = 18'(32'h3000 + i); cpu_data = 12'(32'h500 + i);
            cpu_exp_q.push_back({18'(32'h3000 + i), 12'(32'h500 + i)});
            nxt();
        end
        cpu_wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({vram_we, vram_addr, vram_data, cpu_full, cpu_ovf, fill_busy, fill_done} !== '0) begin
            failures++;
            $display("FAIL reset_async got we=%b addr=%h data=%h full=%b ovf=%b busy=%b done=%b expected all 0",
                     vram_we, vram_addr, vram_data, cpu_full, cpu_ovf, fill_busy, fill_done);
        end
        cpu_exp_q.delete();
        fill_exp_q.delete();
        nxt();
        nxt();
        base = we_cnt; dbase = done_cnt;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) nxt();
        checks++;
        if (we_cnt != base || done_cnt != dbase || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_after got writes=%0d dones=%0d busy=%b expected 0 0 0",
                     we_cnt - base, done_cnt - dbase, fill_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_cpu();
        test_back_to_back();
        test_fill_alone();
        test_contention();
        test_overflow();
        test_zero_restart();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
